// File: rtl/ecc_hamming_74_pkg.sv
// ecc_hamming_74_pkg: shared types and codeword layout for the (7,4) SEC-DED scrubber
package ecc_hamming_74_pkg;
    localparam int ECC_WORD_W = 8;
    localparam int POS_P1 = 0;
    localparam int POS_P2 = 1;
    localparam int POS_P4 = 3;
    localparam int POS_D0 = 2;
    localparam int POS_D1 = 4;
    localparam int POS_D2 = 5;
    localparam int POS_D3 = 6;
    typedef enum logic [2:0] {IDLE, HOST_RD, HOST_CHK, SCRUB_RD, SCRUB_CHK, SCRUB_WB} state_t;
    typedef enum logic {GRANT_HOST, GRANT_SCRUB} grant_t;
endpackage

// File: rtl/ecc_hamming_74_scrubber_if.sv
// ecc_hamming_74_scrubber_if: host read request/response channel
interface ecc_hamming_74_scrubber_if #(parameter int AW = 8);
    logic          host_rd_valid;
    logic          host_rd_ready;
    logic [AW-1:0] host_rd_addr;
    logic          host_rsp_valid;
    logic [3:0]    host_rsp_data;
    logic [1:0]    host_rsp_err;
    modport master (output host_rd_valid, host_rd_addr,
                    input  host_rd_ready, host_rsp_valid, host_rsp_data, host_rsp_err);
    modport slave  (input  host_rd_valid, host_rd_addr,
                    output host_rd_ready, host_rsp_valid, host_rsp_data, host_rsp_err);
endinterface

// File: rtl/ecc_hamming_74_scrubber_decoder.sv
// ecc_hamming_74_decoder: (7,4) Hamming syndrome, corrected data and SEC-DED classification
module ecc_hamming_74_decoder
    import ecc_hamming_74_pkg::*;
(
    input  logic [ECC_WORD_W-1:0] word,
    output logic [2:0]            syndrome,
    output logic [3:0]            data,
    output logic                  single_err,
    output logic                  double_err
);
    logic [6:0] cw_fix;
    assign syndrome = {word[POS_P4] ^ word[POS_D1] ^ word[POS_D2] ^ word[POS_D3],
                       word[POS_P2] ^ word[POS_D0] ^ word[POS_D2] ^ word[POS_D3],
                       word[POS_P1] ^ word[POS_D0] ^ word[POS_D1] ^ word[POS_D3]};
    assign cw_fix = word[6:0] ^ 7'((8'd1 << syndrome) >> 1);
    assign data = {cw_fix[POS_D3], cw_fix[POS_D2], cw_fix[POS_D1], cw_fix[POS_D0]};
    // Odd overall parity means one flipped bit, including the extra-parity bit itself
    assign single_err = ^word;
    assign double_err = !single_err && |syndrome;
endmodule

// File: rtl/ecc_hamming_74_scrubber.sv
// ecc_hamming_74_scrubber: RAM port owner arbitrating host reads and a background ECC scrubber
module ecc_hamming_74_scrubber
    import ecc_hamming_74_pkg::*;
#(
    parameter int AW             = 8,
    parameter int SCRUB_INTERVAL = 1024,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scrub_en,
    input  logic                  clr_stat,
    ecc_hamming_74_scrubber_if.slave host,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [ECC_WORD_W-1:0] mem_wdata,
    input  logic [ECC_WORD_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]      err_single_cnt,
    output logic [CNT_W-1:0]      err_double_cnt,
    output logic                  dbe_flag,
    output logic [AW-1:0]         dbe_addr,
    output logic                  scrub_busy
);
    localparam int IVL_W = $clog2(SCRUB_INTERVAL);
    state_t state, state_nx;
    grant_t last_grant;
    logic [IVL_W-1:0] ivl_cnt;
    logic ivl_wrap, scrub_pending, scrub_grant, host_grant, chk;
    logic [AW-1:0] scrub_addr, addr_q;
    logic [ECC_WORD_W-1:0] dec_word;
    logic [2:0] syndrome;
    logic [3:0] dec_data;
    logic single_err, double_err;
    logic [6:0] cw_fix;

    assign chk = state == HOST_CHK || state == SCRUB_CHK;
    assign dec_word = chk ? mem_rdata : '0;

    ecc_hamming_74_decoder u_dec (
        .word       (dec_word),
        .syndrome   (syndrome),
        .data       (dec_data),
        .single_err (single_err),
        .double_err (double_err)
    );

    assign cw_fix = mem_rdata[6:0] ^ 7'((8'd1 << syndrome) >> 1);
    assign ivl_wrap = ivl_cnt == IVL_W'(SCRUB_INTERVAL - 1);
    // Under contention the scrubber wins only if the host had the previous grant
    assign scrub_grant = state == IDLE && scrub_en && scrub_pending &&
                         (!host.host_rd_valid || last_grant == GRANT_HOST);
    assign host.host_rd_ready = state == IDLE && !scrub_grant;
    assign host_grant = host.host_rd_valid && host.host_rd_ready;
    assign mem_req = state inside {HOST_RD, SCRUB_RD, SCRUB_WB};
    assign mem_we = state == SCRUB_WB;
    assign mem_addr = addr_q;
    assign scrub_busy = state inside {SCRUB_RD, SCRUB_CHK, SCRUB_WB};

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:      state_nx = scrub_grant ? SCRUB_RD : host_grant ? HOST_RD : IDLE;
            HOST_RD:   state_nx = HOST_CHK;
            SCRUB_RD:  state_nx = SCRUB_CHK;
            SCRUB_CHK: state_nx = single_err ? SCRUB_WB : IDLE;
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= IDLE;
            last_grant           <= GRANT_SCRUB;
            ivl_cnt              <= '0;
            scrub_pending        <= 1'b0;
            scrub_addr           <= '0;
            addr_q               <= '0;
            mem_wdata            <= '0;
            host.host_rsp_valid  <= 1'b0;
            host.host_rsp_data   <= '0;
            host.host_rsp_err    <= '0;
            err_single_cnt       <= '0;
            err_double_cnt       <= '0;
            dbe_flag             <= 1'b0;
            dbe_addr             <= '0;
        end else begin
            state <= state_nx;
            if (scrub_en) ivl_cnt <= ivl_wrap ? '0 : ivl_cnt + 1'b1;
            scrub_pending <= (scrub_en && ivl_wrap) || (scrub_pending && state != SCRUB_RD);
            if (scrub_grant) begin
                last_grant <= GRANT_SCRUB;
                addr_q     <= scrub_addr;
            end else if (host_grant) begin
                last_grant <= GRANT_HOST;
                addr_q     <= host.host_rd_addr;
            end
            if (state == SCRUB_CHK) begin
                scrub_addr <= scrub_addr + 1'b1;
                mem_wdata  <= {^cw_fix, cw_fix};
            end
            host.host_rsp_valid <= state == HOST_CHK;
            if (state == HOST_CHK) begin
                host.host_rsp_data <= dec_data;
                host.host_rsp_err  <= {double_err, single_err};
            end
            if (clr_stat) begin
                err_single_cnt <= '0;
                err_double_cnt <= '0;
                dbe_flag       <= 1'b0;
                dbe_addr       <= '0;
            end else if (chk) begin
                if (single_err && !(&err_single_cnt)) err_single_cnt <= err_single_cnt + 1'b1;
                if (double_err && !(&err_double_cnt)) err_double_cnt <= err_double_cnt + 1'b1;
                if (double_err && !dbe_flag) begin
                    dbe_flag <= 1'b1;
                    dbe_addr <= addr_q;
                end
            end
        end
    end
endmodule

// File: tb/tb_ecc_hamming_74_scrubber.sv
// tb_ecc_hamming_74_scrubber: directed checks of host reads, scrubbing, statistics and reset abort
module tb_ecc_hamming_74_scrubber;
    localparam int AW = 8;
    logic clk = 1'b0, rst_n = 1'b1, scrub_en = 1'b0, clr_stat = 1'b0;
    logic mem_req, mem_we, dbe_flag, scrub_busy;
    logic [AW-1:0] mem_addr, dbe_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic [3:0] err_single_cnt, err_double_cnt;
    logic [7:0] mem [256];
    logic wipe = 1'b1, poke_en = 1'b0, cont = 1'b0;
    logic [7:0] poke_addr = '0, poke_data = '0, exp_saddr = '0;
    logic prev_scrub = 1'b0;
    int tests_run = 0, tests_failed = 0;
    int scrub_reads = 0, host_reads = 0, host_rsps = 0, wr_cnt = 0;

    ecc_hamming_74_scrubber_if #(.AW(AW)) host_if();

    ecc_hamming_74_scrubber #(.AW(AW), .SCRUB_INTERVAL(8), .CNT_W(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .scrub_en       (scrub_en),
        .clr_stat       (clr_stat),
        .host           (host_if),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .err_single_cnt (err_single_cnt),
        .err_double_cnt (err_double_cnt),
        .dbe_flag       (dbe_flag),
        .dbe_addr       (dbe_addr),
        .scrub_busy     (scrub_busy)
    );

    always #5 clk = ~clk;

    // RAM model: one-cycle read latency, DUT writes take precedence over bench pokes
    always @(posedge clk) begin
        if (wipe) for (int i = 0; i < 256; i++) mem[i] <= '0;
        else if (mem_req && mem_we) mem[mem_addr] <= mem_wdata;
        else if (poke_en) mem[poke_addr] <= poke_data;
        if (mem_req && !mem_we) mem_rdata <= mem[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_saddr  = '0;
            prev_scrub = 1'b0;
        end else begin
            if (mem_req && mem_we) wr_cnt++;
            if (mem_req && !mem_we) begin
                if (scrub_busy) begin
                    check("scrub_addr", mem_addr, exp_saddr);
                    if (cont) check("alternate", prev_scrub, 0);
                    exp_saddr++;
                    scrub_reads++;
                    prev_scrub = 1'b1;
                end else begin
                    host_reads++;
                    prev_scrub = 1'b0;
                end
            end
            if (cont && host_if.host_rsp_valid) begin
                host_rsps++;
                check("cont_rsp", {host_if.host_rsp_err, host_if.host_rsp_data}, 0);
            end
        end
    end

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic host_read(input logic [7:0] a, input logic [3:0] d, input logic [1:0] e,
                             input logic clr_at_chk);
        int n = 0;
        @(negedge clk);
        host_if.host_rd_valid = 1'b1; host_if.host_rd_addr = a;
        #1;
        while (!host_if.host_rd_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        check("rd_ready", host_if.host_rd_ready, 1);
        @(negedge clk);
        host_if.host_rd_valid = 1'b0;
        check("rd_mem_req", mem_req, 1);
        check("rd_mem_addr", mem_addr, a);
        @(negedge clk);
        check("rsp_early", host_if.host_rsp_valid, 0);
        clr_stat = clr_at_chk;
        @(negedge clk);
        clr_stat = 1'b0;
        check("rsp_valid", host_if.host_rsp_valid, 1);
        check("rsp_data", host_if.host_rsp_data, d);
        check("rsp_err", host_if.host_rsp_err, e);
        check("ready_t3", host_if.host_rd_ready, 1);
        @(negedge clk);
        check("rsp_once", host_if.host_rsp_valid, 0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_mem_req"}, mem_req, 0);
        check({tag, "_mem_we"}, mem_we, 0);
        check({tag, "_mem_addr"}, mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_rsp"}, {host_if.host_rsp_valid, host_if.host_rsp_err, host_if.host_rsp_data}, 0);
        check({tag, "_cnts"}, {err_single_cnt, err_double_cnt}, 0);
        check({tag, "_dbe"}, {dbe_flag, dbe_addr}, 0);
        check({tag, "_busy"}, scrub_busy, 0);
    endtask

    initial begin
        int n, hr0;
        host_if.host_rd_valid = 1'b0;
        host_if.host_rd_addr  = '0;
        #2 rst_n = 1'b0;
        #1 check_idle_outputs("reset");
        repeat (3) @(negedge clk);
        wipe  = 1'b0;
        rst_n = 1'b1;

        // Clean RAM host read, then a valid codeword for 4'hB and a single-bit corruption of it
        host_read(8'd5, 4'h0, 2'b00, 1'b0);
        check("clean_cnts", {err_single_cnt, err_double_cnt}, 0);
        poke(8'd20, 8'h55);
        poke(8'd21, 8'h15);
        host_read(8'd20, 4'hB, 2'b00, 1'b0);
        host_read(8'd21, 4'hB, 2'b01, 1'b0);
        check("host_single_cnt", err_single_cnt, 1);
        check("host_no_wb", mem[21], 8'h15);
        @(negedge clk); clr_stat = 1'b1;
        @(negedge clk); clr_stat = 1'b0;
        check("clr1_single", err_single_cnt, 0);

        // Scrub addresses 0..13 over planted single, parity-only and double errors
        poke(8'd3, 8'h10);
        poke(8'd2, 8'h80);
        poke(8'd9, 8'h21);
        poke(8'd12, 8'h21);
        @(negedge clk); scrub_en = 1'b1;
        n = 0;
        while (scrub_reads < 14 && n < 3000) begin @(negedge clk); #1; n++; end
        check("scrub_reach13", scrub_reads >= 14, 1);
        scrub_en = 1'b0;
        repeat (10) @(negedge clk);
        check("scrub_idle", scrub_busy, 0);
        check("wb_addr3", mem[3], 8'h00);
        check("wb_addr2", mem[2], 8'h00);
        check("nowb_addr9", mem[9], 8'h21);
        check("nowb_addr12", mem[12], 8'h21);
        check("wb_count", wr_cnt, 2);
        check("scrub_single", err_single_cnt, 2);
        check("scrub_double", err_double_cnt, 2);
        check("dbe_flag", dbe_flag, 1);
        check("dbe_addr", dbe_addr, 9);
        host_read(8'd3, 4'h0, 2'b00, 1'b0);
        check("reread_single", err_single_cnt, 2);
        @(negedge clk); clr_stat = 1'b1;
        @(negedge clk); clr_stat = 1'b0;
        check("clr2_cnts", {err_single_cnt, err_double_cnt}, 0);
        check("clr2_dbe", {dbe_flag, dbe_addr}, 0);

        // Saturation, then a clear coinciding with an increment
        poke(8'd40, 8'h10);
        for (int i = 0; i < 20; i++) host_read(8'd40, 4'h0, 2'b01, 1'b0);
        check("sat_single", err_single_cnt, 4'hF);
        check("sat_double", err_double_cnt, 0);
        host_read(8'd40, 4'h0, 2'b01, 1'b1);
        check("clr_wins", err_single_cnt, 0);

        // Continuous host traffic against a pending scrubber, through the address wrap
        hr0 = host_reads;
        @(negedge clk);
        cont = 1'b1;
        host_if.host_rd_addr  = 8'd7;
        host_if.host_rd_valid = 1'b1;
        scrub_en = 1'b1;
        n = 0;
        while (scrub_reads < 257 && n < 20000) begin @(negedge clk); #1; n++; end
        check("scrub_wrap_reached", scrub_reads >= 257, 1);
        host_if.host_rd_valid = 1'b0;
        scrub_en = 1'b0;
        repeat (10) @(negedge clk);
        cont = 1'b0;
        check("cont_rsp_count", host_rsps, host_reads - hr0);
        check("cont_host_progress", host_rsps > 100, 1);
        check("cont_fix21", mem[21], 8'h55);
        check("cont_fix40", mem[40], 8'h00);

        // Reset asserted while a writeback is on the port
        poke(exp_saddr, 8'h10);
        @(negedge clk); scrub_en = 1'b1;
        n = 0;
        while (!(mem_req && mem_we) && n < 200) begin @(negedge clk); n++; end
        check("wb_seen", mem_we, 1);
        rst_n = 1'b0;
        #1 check_idle_outputs("abort");
        scrub_en = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_write", mem[1], 8'h10);
        host_read(8'd5, 4'h0, 2'b00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
